// File: rtl/store_narrower_pkg.sv
// store_pkg
// Shared definitions for the store narrower: access-size encodings, the
// FSM state type, the number of byte lanes in a memory word, and the
// truncation check applied to a register value before it is narrowed.
// No ports (package).

package store_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT1 = 2'b01,
        BEAT2 = 2'b10,
        FIN   = 2'b11
    } state_t;

    // A narrowed value is representable only when every discarded upper bit
    // equals the sign bit of the stored field, i.e. the register held a pure
    // sign extension of that field.
    function automatic logic isTrunc(input logic [31:0] data, input logic [1:0] size);
        logic result;
        result = 1'b0;
        case (size)
            SZ_BYTE: result = !((&data[31:7])  || !(|data[31:7]));
            SZ_HALF: result = !((&data[31:15]) || !(|data[31:15]));
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/store_narrower_lane_shifter.sv
// lane_shifter
// Positions a store value onto little-endian byte lanes across two adjacent
// memory words and builds the matching 8-bit byte-enable mask.
// Ports:
//   i_data  [31:0]  register value to store
//   i_k     [1:0]   byte offset within the first word
//   i_size  [1:0]   access size (byte/half/word/illegal)
//   o_wide  [63:0]  data shifted up by 8*k bits; [31:0] first word, [63:32] second
//   o_mask  [7:0]   byte enables; [3:0] first word, [7:4] second

module lane_shifter
    import store_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_k,
    input  logic [1:0]  i_size,
    output logic [63:0] o_wide,
    output logic [7:0]  o_mask
);

    logic [LANES-1:0] w_base;

    // Illegal size gets an empty mask so it can never enable a lane.
    always_comb begin
        w_base = '0;
        case (i_size)
            SZ_BYTE: w_base = 4'b0001;
            SZ_HALF: w_base = 4'b0011;
            SZ_WORD: w_base = 4'b1111;
            default: w_base = 4'b0000;
        endcase
        o_wide = {32'b0, i_data} << {i_k, 3'b000};
        o_mask = {4'b0000, w_base} << i_k;
    end

endmodule

// File: rtl/store_narrower.sv
// store_narrower
// Narrows a 32-bit register value to byte/half/word and issues one or two
// aligned write beats with byte enables. Stores that straddle a word
// boundary are split into two beats; the second beat targets the next word
// (32-bit wrap). Reports truncation (upper bits not a sign extension) and an
// illegal-size error with the one-cycle done pulse.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_data/req_addr/req_size store value, byte address, size
//   mem_valid/mem_ready        write beat handshake
//   mem_addr/mem_wdata/mem_be  word address, lane data, byte enables
//   done, trunc, err_size      retirement pulse and its status flags

module store_narrower
    import store_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        done,
    output logic        trunc,
    output logic        err_size
);

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_memAddr;
    logic [31:0] r_memWdata;
    logic [3:0]  r_memBe;
    logic [31:0] r_hiWdata;
    logic [3:0]  r_hiBe;
    logic        r_trunc;
    logic        r_errSize;

    logic [63:0] w_wide;
    logic [7:0]  w_mask;
    logic        w_legal;

    lane_shifter u_lane_shifter (
        .i_data (req_data),
        .i_k    (req_addr[1:0]),
        .i_size (req_size),
        .o_wide (w_wide),
        .o_mask (w_mask)
    );

    assign w_legal = (req_size != SZ_ILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A second beat is needed exactly when the upper half of the mask,
    // captured at accept time, has any lane enabled.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next = w_legal ? BEAT1 : FIN;
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    w_next = (r_hiBe != 4'b0000) ? BEAT2 : FIN;
                end
            end
            BEAT2: begin
                if (mem_ready) begin
                    w_next = FIN;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Beat registers are loaded on accept, swapped to the upper word after
    // the first handshake of a split, and cleared once the last beat is
    // taken so nothing stale remains visible between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memBe    <= '0;
            r_hiWdata  <= '0;
            r_hiBe     <= '0;
            r_trunc    <= 1'b0;
            r_errSize  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_trunc   <= isTrunc(req_data, req_size);
                        r_errSize <= !w_legal;
                        if (w_legal) begin
                            r_memAddr  <= {req_addr[31:2], 2'b00};
                            r_memWdata <= w_wide[31:0];
                            r_memBe    <= w_mask[3:0];
                            r_hiWdata  <= w_wide[63:32];
                            r_hiBe     <= w_mask[7:4];
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        if (r_hiBe != 4'b0000) begin
                            r_memAddr  <= r_memAddr + 32'd4;
                            r_memWdata <= r_hiWdata;
                            r_memBe    <= r_hiBe;
                        end else begin
                            r_memAddr  <= '0;
                            r_memWdata <= '0;
                            r_memBe    <= '0;
                        end
                        r_hiWdata <= '0;
                        r_hiBe    <= '0;
                    end
                end
                BEAT2: begin
                    if (mem_ready) begin
                        r_memAddr  <= '0;
                        r_memWdata <= '0;
                        r_memBe    <= '0;
                    end
                end
                FIN: begin
                    r_trunc   <= 1'b0;
                    r_errSize <= 1'b0;
                end
                default: begin
                    r_memAddr  <= '0;
                    r_memWdata <= '0;
                    r_memBe    <= '0;
                end
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign mem_valid = (r_state == BEAT1) || (r_state == BEAT2);
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_be    = r_memBe;
    assign done      = (r_state == FIN);
    assign trunc     = (r_state == FIN) && r_trunc;
    assign err_size  = (r_state == FIN) && r_errSize;

endmodule

// File: tb/tb_store_narrower.sv
// tb_store_narrower
// Directed bench for store_narrower: aligned, truncating, split, stalled,
// wrapping, illegal-size and mid-beat reset cases with hand-computed values.

module tb_store_narrower;

    import store_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        trunc;
    logic        err_size;

    int assertCount = 0;
    int failCount   = 0;

    store_narrower dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .done      (done),
        .trunc     (trunc),
        .err_size  (err_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [31:0] addr, input logic [1:0] size);
        req_valid = 1'b1;
        req_data  = data;
        req_addr  = addr;
        req_size  = size;
        checkOutput("accept_ready", {31'b0, req_ready}, 32'd1);
        stepClock();
        req_valid = 1'b0;
        req_data  = 32'h0;
        req_addr  = 32'h0;
        req_size  = 2'b00;
    endtask

    task automatic checkBeat(input string tag, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        checkOutput({tag, "_valid"}, {31'b0, mem_valid}, 32'd1);
        checkOutput({tag, "_addr"},  mem_addr, addr);
        checkOutput({tag, "_wdata"}, mem_wdata, wdata);
        checkOutput({tag, "_be"},    {28'b0, mem_be}, {28'b0, be});
        checkOutput({tag, "_nodone"}, {31'b0, done}, 32'd0);
    endtask

    task automatic checkDone(input string tag, input logic expTrunc, input logic expErr);
        checkOutput({tag, "_done"},  {31'b0, done}, 32'd1);
        checkOutput({tag, "_trunc"}, {31'b0, trunc}, {31'b0, expTrunc});
        checkOutput({tag, "_err"},   {31'b0, err_size}, {31'b0, expErr});
        checkOutput({tag, "_novalid"}, {31'b0, mem_valid}, 32'd0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_done0"}, {31'b0, done}, 32'd0);
        checkOutput({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        checkOutput({tag, "_valid0"}, {31'b0, mem_valid}, 32'd0);
        checkOutput({tag, "_be0"}, {28'b0, mem_be}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data  = 32'h0;
        req_addr  = 32'h0;
        req_size  = 2'b00;
        mem_ready = 1'b1;

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("rst_done",  {31'b0, done}, 32'd0);
        checkOutput("rst_trunc", {31'b0, trunc}, 32'd0);
        checkOutput("rst_err",   {31'b0, err_size}, 32'd0);
        checkOutput("rst_be",    {28'b0, mem_be}, 32'd0);
        checkOutput("rst_addr",  mem_addr, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        stepClock();

        // Byte store, lane 2, sign-extended value: no truncation.
        applyStimulus(32'hFFFFFF85, 32'h00001002, SZ_BYTE);
        checkBeat("byte_b1", 32'h00001000, 32'hFF850000, 4'b0100);
        stepClock();
        checkDone("byte", 1'b0, 1'b0);
        stepClock();
        checkIdle("byte_after");

        // Half store with bit 16 set: truncation flagged.
        applyStimulus(32'h00012345, 32'h00002000, SZ_HALF);
        checkBeat("half_b1", 32'h00002000, 32'h00012345, 4'b0011);
        stepClock();
        checkDone("half", 1'b1, 1'b0);
        stepClock();

        // Byte at offset 3 never splits.
        applyStimulus(32'h0000007F, 32'h00007003, SZ_BYTE);
        checkBeat("byte3_b1", 32'h00007000, 32'h7F000000, 4'b1000);
        stepClock();
        checkDone("byte3", 1'b0, 1'b0);
        stepClock();

        // Split half at offset 3: done at cycle 3.
        applyStimulus(32'h0000BEEF, 32'h00003003, SZ_HALF);
        checkBeat("shalf_b1", 32'h00003000, 32'hEF000000, 4'b1000);
        stepClock();
        checkBeat("shalf_b2", 32'h00003004, 32'h000000BE, 4'b0001);
        stepClock();
        checkDone("shalf", 1'b1, 1'b0);
        stepClock();

        // Split word with two stall cycles on each beat.
        mem_ready = 1'b0;
        applyStimulus(32'hA1B2C3D4, 32'h00004001, SZ_WORD);
        checkBeat("sword_b1", 32'h00004000, 32'hB2C3D400, 4'b1110);
        for (int i = 0; i < 2; i++) begin
            stepClock();
            checkBeat("sword_b1_stall", 32'h00004000, 32'hB2C3D400, 4'b1110);
        end
        mem_ready = 1'b1;
        stepClock();
        mem_ready = 1'b0;
        checkBeat("sword_b2", 32'h00004004, 32'h000000A1, 4'b0001);
        for (int i = 0; i < 2; i++) begin
            stepClock();
            checkBeat("sword_b2_stall", 32'h00004004, 32'h000000A1, 4'b0001);
        end
        mem_ready = 1'b1;
        stepClock();
        checkDone("sword", 1'b0, 1'b0);
        stepClock();

        // Word straddling the top of the address space wraps to zero.
        applyStimulus(32'h11223344, 32'hFFFFFFFE, SZ_WORD);
        checkBeat("wrap_b1", 32'hFFFFFFFC, 32'h33440000, 4'b1100);
        stepClock();
        checkBeat("wrap_b2", 32'h00000000, 32'h00001122, 4'b0011);
        stepClock();
        checkDone("wrap", 1'b0, 1'b0);
        stepClock();

        // Illegal size retires at cycle 1 without a memory beat.
        applyStimulus(32'h12345678, 32'h00005000, SZ_ILL);
        checkDone("ill", 1'b0, 1'b1);
        checkOutput("ill_be", {28'b0, mem_be}, 32'd0);
        stepClock();
        checkIdle("ill_after");

        // Reset during the second beat of a split aborts without done.
        applyStimulus(32'hA1B2C3D4, 32'h00004001, SZ_WORD);
        checkBeat("rstmid_b1", 32'h00004000, 32'hB2C3D400, 4'b1110);
        stepClock();
        checkBeat("rstmid_b2", 32'h00004004, 32'h000000A1, 4'b0001);
        rst_n = 1'b0;
        #1;
        checkIdle("rstmid");
        checkOutput("rstmid_addr",  mem_addr, 32'd0);
        checkOutput("rstmid_wdata", mem_wdata, 32'd0);
        checkOutput("rstmid_trunc", {31'b0, trunc}, 32'd0);
        checkOutput("rstmid_err",   {31'b0, err_size}, 32'd0);
        stepClock();
        rst_n = 1'b1;
        stepClock();
        checkIdle("rstmid_post");

        // Recovery: aligned word after the abort.
        applyStimulus(32'hDEADBEEF, 32'h00006000, SZ_WORD);
        checkBeat("recov_b1", 32'h00006000, 32'hDEADBEEF, 4'b1111);
        stepClock();
        checkDone("recov", 1'b0, 1'b0);
        stepClock();
        checkIdle("recov_after");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/store_narrower.md
# store_narrower

Store-side counterpart of the immediate/load sign extender in the single-cycle MIPS datapath. Accepts a 32-bit register value with a byte address and access size, narrows it to byte, halfword or word, and drives aligned 32-bit write beats with byte enables to data memory. Stores that cross a word boundary are split into two beats. Flags values whose discarded upper bits are not a pure sign extension of the stored field, which is the inverse check of sign extension.

## Interface
- No parameters; data width fixed at 32, little-endian byte lanes.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_data  in  32  register value to store.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_valid  out  1  write beat present.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-positioned write data.
- mem_be  out  4  byte enables, bit i = lane i.
- done  out  1  one-cycle pulse: request retired.
- trunc  out  1  valid with done: narrowed value not representable.
- err_size  out  1  valid with done: req_size was 11.

## Operation
- States: IDLE, BEAT1, BEAT2, FIN.
- IDLE: req_ready=1. On req_valid: capture data, addr, size; compute flags. Size 11 -> FIN with err_size=1, no memory beat. Otherwise -> BEAT1.
- Lane formation: k=addr[1:0]; n = 1/2/4 bytes; wide = {32'b0,data} << 8k (64 bits); mask = ((1<<n)-1) << k (8 bits).
- BEAT1: mem_addr=A, mem_wdata=wide[31:0], mem_be=mask[3:0]. On mem_ready: -> BEAT2 if mask[7:4]!=0, else FIN.
- BEAT2: mem_addr=A+4 (32-bit wrap), mem_wdata=wide[63:32], mem_be=mask[7:4]. On mem_ready -> FIN.
- FIN: done=1 for exactly one cycle, with trunc/err_size; -> IDLE.
- trunc: byte -> data[31:7] not all equal; half -> data[31:15] not all equal; word -> 0. The store still proceeds with the low n bytes.
- Splits: byte never; half at k=3; word at k!=0.
- Disabled lanes in mem_wdata carry shifted data or zero, never stale data from an earlier request.

## Timing
- Reset: state IDLE. mem_valid, done, trunc, err_size, mem_be are 0; mem_addr and mem_wdata are 0. req_ready=1 while in reset.
- All outputs are registered or decoded from state only; there are no combinational paths from req_* or mem_ready to outputs.
- Latency with mem_ready held high: aligned store has accept at cycle 0, BEAT1 at cycle 1, done at cycle 2. Split store has done at cycle 3. Illegal size has done at cycle 1.
- mem_valid is held, and mem_addr, mem_wdata and mem_be are stable, until the mem_ready handshake. Each stall cycle adds one cycle of latency.
- A new request is accepted in the cycle after done, when the unit is back in IDLE; there is no overlap.
- Reset asserted mid-beat aborts immediately. A partial split write (BEAT1 done, BEAT2 not) is the issuer's concern; no done is produced.

## Structure
- Package store_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, lane count 4.
- Sub-module lane_shifter: combinational 64-bit data shift and 8-bit mask generation from (data, k, size), instanced once.

## Test plan
- Byte store: data=0xFFFFFF85, addr=0x1002. Required: one beat with mem_addr=0x1000, be=0100, wdata[23:16]=0x85; done with trunc=0.
- Half truncation: data=0x00012345, addr=0x2000. Required: be=0011, wdata[15:0]=0x2345; trunc=1.
- Split half: data=0x0000BEEF, addr=0x3003. Required: beat1 0x3000 be=1000 wdata[31:24]=0xEF; beat2 0x3004 be=0001 wdata[7:0]=0xBE; done at cycle 3.
- Split word with stalls: data=0xA1B2C3D4, addr=0x4001, mem_ready low for 2 cycles per beat. Required: beat1 be=1110 wdata=0xB2C3D4xx, beat2 be=0001 wdata[7:0]=0xA1; outputs stable while stalled.
- Address wrap: word at addr=0xFFFFFFFE. Required: beat2 mem_addr=0x00000000 be=0011.
- Illegal size and reset: size=11 gives done with err_size=1 at cycle 1 and no mem_valid. rst_n low during BEAT2 returns the unit to IDLE with all outputs 0.
